// File: rtl/carrier_lock_ctrl.sv
// Carrier-recovery loop sequencer: gates/clears the loop, picks gain,
// and declares lock from windowed mean |phase error| with hysteresis.
module carrier_lock_ctrl #(
    parameter int EW          = 24,
    parameter int WIN_LOG2    = 4,
    parameter int ACQ_MIN_WIN = 2,
    parameter int LOCK_WINS   = 3,
    parameter int UNLOCK_WINS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          err_valid,
    input  logic [EW-1:0] phase_err,
    input  logic [EW-1:0] lock_thr,
    input  logic [EW-1:0] unlock_thr,
    output logic          loop_en,
    output logic          loop_clr,
    output logic [1:0]    gain_sel,
    output logic          locked,
    output logic [1:0]    state,
    output logic          win_valid,
    output logic [EW-1:0] win_mag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CLEAR = 2'b01,
        S_ACQ   = 2'b10,
        S_TRACK = 2'b11
    } state_t;

    localparam int AW = EW - 1 + WIN_LOG2;
    localparam int CW = 8;

    state_t              st;
    logic [WIN_LOG2-1:0] smp_cnt;
    logic [AW-1:0]       acc;
    logic [CW-1:0]       acq_win;
    logic [CW-1:0]       good_cnt;
    logic [CW-1:0]       bad_cnt;

    logic [EW-1:0]       neg_err;
    logic [EW-2:0]       mag;
    logic [AW-1:0]       sum;
    logic [EW-1:0]       mean;
    logic                win_done;
    logic [CW-1:0]       good_nxt;
    logic [CW-1:0]       bad_nxt;

    assign state = st;

    // Saturating magnitude, running window sum and per-window decisions
    always_comb begin
        neg_err = -phase_err;
        mag     = phase_err[EW-2:0];
        if (phase_err[EW-1]) begin
            mag = neg_err[EW-1] ? '1 : neg_err[EW-2:0];
        end
        sum      = acc + AW'(mag);
        mean     = {1'b0, sum[AW-1:WIN_LOG2]};
        win_done = err_valid && (smp_cnt == '1);
        good_nxt = '0;
        if (acq_win == CW'(ACQ_MIN_WIN) && mean < lock_thr) begin
            good_nxt = good_cnt + CW'(1);
        end
        bad_nxt = '0;
        if (mean >= unlock_thr) begin
            bad_nxt = bad_cnt + CW'(1);
        end
    end

    // Loop sequencer with registered outputs and window bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            loop_en   <= 1'b0;
            loop_clr  <= 1'b0;
            gain_sel  <= 2'b00;
            locked    <= 1'b0;
            win_valid <= 1'b0;
            win_mag   <= '0;
            smp_cnt   <= '0;
            acc       <= '0;
            acq_win   <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            win_valid <= 1'b0;
            loop_clr  <= 1'b0;
            if (!enable) begin
                st       <= S_IDLE;
                loop_en  <= 1'b0;
                gain_sel <= 2'b00;
                locked   <= 1'b0;
                smp_cnt  <= '0;
                acc      <= '0;
                acq_win  <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else begin
                unique case (st)
                    S_IDLE: begin
                        st       <= S_CLEAR;
                        loop_clr <= 1'b1;
                    end
                    S_CLEAR: begin
                        st       <= S_ACQ;
                        loop_en  <= 1'b1;
                        gain_sel <= 2'b00;
                        smp_cnt  <= '0;
                        acc      <= '0;
                        acq_win  <= '0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                    S_ACQ, S_TRACK: begin
                        if (err_valid) begin
                            smp_cnt <= smp_cnt + 1'b1;
                            acc     <= sum;
                        end
                        if (win_done) begin
                            smp_cnt   <= '0;
                            acc       <= '0;
                            win_valid <= 1'b1;
                            win_mag   <= mean;
                            if (st == S_ACQ) begin
                                if (acq_win != CW'(ACQ_MIN_WIN)) begin
                                    acq_win <= acq_win + CW'(1);
                                end
                                good_cnt <= good_nxt;
                                if (good_nxt == CW'(LOCK_WINS)) begin
                                    st       <= S_TRACK;
                                    locked   <= 1'b1;
                                    gain_sel <= 2'b01;
                                    bad_cnt  <= '0;
                                end
                            end else begin
                                bad_cnt <= bad_nxt;
                                if (bad_nxt == CW'(UNLOCK_WINS)) begin
                                    st       <= S_CLEAR;
                                    locked   <= 1'b0;
                                    loop_en  <= 1'b0;
                                    loop_clr <= 1'b1;
                                    gain_sel <= 2'b00;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
